// File: rtl/pipe_seq_ctrl.sv
// rtl/pipe_seq_ctrl.sv - D/E pipeline sequencing controller: load-use stalls, flushes, CALL/RET/INT micro-sequences
module pipe_seq_ctrl #(
    parameter int REG_W      = 3,
    parameter int LU_BUBBLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec_valid,
    input  logic [1:0]       dec_kind,
    input  logic [REG_W-1:0] dec_src1,
    input  logic [REG_W-1:0] dec_src2,
    input  logic             dec_use1,
    input  logic             dec_use2,
    input  logic             ex_mr,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_rw,
    input  logic             br_taken,
    input  logic             int_req,
    output logic             fd_hold,
    output logic             de_bubble,
    output logic             fd_flush,
    output logic [1:0]       phase,
    output logic [1:0]       seq_kind,
    output logic             busy
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LU   = 3'd1,
        S1   = 3'd2,
        S2   = 3'd3,
        S3   = 3'd4
    } state_t;

    localparam logic [1:0] KIND_INT = 2'b11;
    localparam logic [1:0] LU_LOAD  = 2'(LU_BUBBLES - 1);

    state_t     r_state;
    logic [1:0] r_cnt;
    logic [1:0] r_kind;
    logic       r_int_pend;
    logic       r_br_pend;

    state_t     w_state_nx;
    logic [1:0] w_cnt_nx;
    logic [1:0] w_kind_nx;
    logic       w_int_pend_nx;
    logic       w_br_pend_nx;
    logic       w_hazard;
    logic       w_br_any;

    assign w_hazard = ex_mr & ex_rw & dec_valid &
                      ((dec_use1 & (dec_src1 == ex_rd)) | (dec_use2 & (dec_src2 == ex_rd)));

    // A flush deferred from inside a sequence counts as a live branch in the first IDLE cycle.
    assign w_br_any = br_taken | r_br_pend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= 2'd0;
            r_kind     <= 2'd0;
            r_int_pend <= 1'b0;
            r_br_pend  <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_cnt      <= w_cnt_nx;
            r_kind     <= w_kind_nx;
            r_int_pend <= w_int_pend_nx;
            r_br_pend  <= w_br_pend_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt;
        w_kind_nx    = r_kind;
        w_br_pend_nx = r_br_pend;
        case (r_state)
            IDLE: begin
                w_br_pend_nx = 1'b0;
                if (w_br_any) begin
                    w_state_nx = IDLE;
                end else if (r_int_pend && !w_hazard) begin
                    w_state_nx = S1;
                    w_kind_nx  = KIND_INT;
                end else if (w_hazard) begin
                    w_state_nx = LU;
                    w_cnt_nx   = LU_LOAD;
                end else if (dec_valid && dec_kind != 2'b00) begin
                    w_state_nx = S1;
                    w_kind_nx  = dec_kind;
                end
            end
            LU: begin
                if (br_taken || r_cnt == 2'd0) begin
                    w_state_nx = IDLE;
                    w_cnt_nx   = 2'd0;
                end else begin
                    w_cnt_nx = r_cnt - 2'd1;
                end
            end
            S1: begin
                w_state_nx = S2;
                if (br_taken) w_br_pend_nx = 1'b1;
            end
            S2: begin
                w_state_nx = (r_kind == KIND_INT) ? S3 : IDLE;
                if (br_taken) w_br_pend_nx = 1'b1;
            end
            S3: begin
                w_state_nx = IDLE;
                if (br_taken) w_br_pend_nx = 1'b1;
            end
            default: begin
                w_state_nx = IDLE;
                w_cnt_nx   = 2'd0;
            end
        endcase
        w_int_pend_nx = (w_state_nx == S1) ? 1'b0 : (r_int_pend | int_req);
    end

    // Moore decodes; only the flush term reacts in the same cycle, and reset masks it.
    always_comb begin
        fd_hold   = 1'b0;
        de_bubble = 1'b0;
        fd_flush  = 1'b0;
        phase     = 2'b00;
        seq_kind  = 2'b00;
        busy      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_br_any && !rst) begin
                    fd_flush  = 1'b1;
                    de_bubble = 1'b1;
                end
            end
            LU: begin
                fd_hold   = 1'b1;
                de_bubble = 1'b1;
                busy      = 1'b1;
                if (br_taken && !rst) fd_flush = 1'b1;
            end
            S1: begin
                phase    = 2'b01;
                fd_hold  = 1'b1;
                busy     = 1'b1;
                seq_kind = r_kind;
            end
            S2: begin
                phase    = 2'b10;
                fd_hold  = (r_kind == KIND_INT);
                busy     = 1'b1;
                seq_kind = r_kind;
            end
            S3: begin
                phase    = 2'b11;
                busy     = 1'b1;
                seq_kind = r_kind;
            end
            default: begin
                fd_hold = 1'b0;
            end
        endcase
    end

endmodule
